// File: rtl/tone_decoder.sv
// tone_decoder: recovers the envelope of a PWM-gated square-wave tone line,
// measures its full period and reports the generator divider code that
// produced it (cand = period/2 - 1), or REST_CODE while the line is silent.
//
// Ports:
//   sys_clk      system clock
//   sys_rst      synchronous active-high reset
//   sound_in     asynchronous 1-bit tone line
//   tone_active  high while a locked tone is present
//   note_target  decoded divider code, or REST_CODE
//   note_valid   one-cycle pulse on every change of note_target
//   period_err   one-cycle pulse when a measured period is out of range
module tone_decoder #(
    parameter int unsigned PWM_WINDOW = 64,
    parameter int unsigned MIN_PERIOD = 90000,
    parameter int unsigned MAX_PERIOD = 1100000,
    parameter int unsigned TOL        = 64,
    parameter logic [31:0] REST_CODE  = 32'hFFFF_FFFF
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        sound_in,
    output logic        tone_active,
    output logic [31:0] note_target,
    output logic        note_valid,
    output logic        period_err
);

    localparam int unsigned CNT_W  = $clog2(MAX_PERIOD + 2);
    localparam int unsigned LOW_W  = $clog2(PWM_WINDOW + 1);
    localparam int unsigned CODE_W = 32;
    localparam int unsigned DIFF_W = 33;

    localparam logic [CNT_W-1:0]  CNT_MIN = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(MAX_PERIOD + 1);
    localparam logic [LOW_W-1:0]  LOW_SAT = LOW_W'(PWM_WINDOW);
    localparam logic [DIFF_W-1:0] TOL_D   = DIFF_W'(TOL);

    typedef enum logic [1:0] {
        SILENT = 2'd0,
        ARM    = 2'd1,
        TRACK  = 2'd2
    } state_e;

    // |a - b| computed in 33-bit signed arithmetic so it never wraps
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [CODE_W-1:0] a,
                                                   input logic [CODE_W-1:0] b);
        logic signed [DIFF_W-1:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < 0) ? DIFF_W'(-d) : DIFF_W'(d);
    endfunction

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic [LOW_W-1:0]  low_cnt_q, low_cnt_d;
    logic              env_q, env_d;
    logic              rise_q, rise_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    state_e            state_q, state_d;
    logic [CODE_W-1:0] prev_q, prev_d;
    logic              tone_active_q, tone_active_d;
    logic [CODE_W-1:0] note_target_q, note_target_d;
    logic              note_valid_q, note_valid_d;
    logic              period_err_q, period_err_d;

    logic              s;
    logic              sat;
    logic              in_range;
    logic              too_short;
    logic [CODE_W-1:0] cand;
    logic              match_prev;
    logic              new_note;

    // Front end: synchronizer, envelope, edge detect and period counter
    always_comb begin
        sync1_d   = sound_in;
        sync2_d   = sync1_q;
        s         = sync2_q;

        // Low-run counter bridges the PWM low gaps inside a tone half-period
        if (s) begin
            low_cnt_d = '0;
        end else if (low_cnt_q == LOW_SAT) begin
            low_cnt_d = LOW_SAT;
        end else begin
            low_cnt_d = low_cnt_q + LOW_W'(1);
        end
        env_d     = s | (env_q & (low_cnt_d != LOW_SAT));
        rise_d    = s & ~env_q;

        if (rise_q) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_SAT) begin
            cnt_d = CNT_SAT;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Silence fires once, on the edge where cnt reaches MAX_PERIOD+1
        sat        = ~rise_q & (cnt_q == CNT_MAX);
        in_range   = (cnt_q >= CNT_MIN) && (cnt_q <= CNT_MAX);
        too_short  = (cnt_q < CNT_MIN);
        cand       = CODE_W'(cnt_q >> 1) - CODE_W'(1);
        match_prev = (abs_diff(cand, prev_q) <= TOL_D);
        new_note   = ~tone_active_q || (abs_diff(cand, note_target_q) > TOL_D);
    end

    // Lock state machine and output word
    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        tone_active_d = tone_active_q;
        note_target_d = note_target_q;
        note_valid_d  = 1'b0;
        period_err_d  = 1'b0;

        if (sat) begin
            state_d       = SILENT;
            period_err_d  = (state_q == TRACK);
            tone_active_d = 1'b0;
            note_target_d = REST_CODE;
            note_valid_d  = (note_target_q != REST_CODE);
        end else if (rise_q) begin
            unique case (state_q)
                SILENT: begin
                    // First rise only starts the measurement
                    state_d = ARM;
                end
                ARM: begin
                    if (in_range) begin
                        prev_d  = cand;
                        state_d = TRACK;
                    end else if (too_short) begin
                        period_err_d = 1'b1;
                    end
                end
                TRACK: begin
                    if (in_range) begin
                        // Publish only when two consecutive periods agree and
                        // the code differs from what is already reported
                        if (match_prev && new_note) begin
                            note_target_d = cand;
                            tone_active_d = 1'b1;
                            note_valid_d  = 1'b1;
                        end
                        prev_d = cand;
                    end else if (too_short) begin
                        period_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = SILENT;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            low_cnt_q     <= '0;
            env_q         <= 1'b0;
            rise_q        <= 1'b0;
            cnt_q         <= '0;
            state_q       <= SILENT;
            prev_q        <= '0;
            tone_active_q <= 1'b0;
            note_target_q <= REST_CODE;
            note_valid_q  <= 1'b0;
            period_err_q  <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            low_cnt_q     <= low_cnt_d;
            env_q         <= env_d;
            rise_q        <= rise_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            prev_q        <= prev_d;
            tone_active_q <= tone_active_d;
            note_target_q <= note_target_d;
            note_valid_q  <= note_valid_d;
            period_err_q  <= period_err_d;
        end
    end

    assign tone_active = tone_active_q;
    assign note_target = note_target_q;
    assign note_valid  = note_valid_q;
    assign period_err  = period_err_q;

endmodule

// File: tb/tb_tone_decoder.sv
// Self-checking bench for tone_decoder, run with scaled-down period limits
// so every scenario fits in a short simulation.
module tb_tone_decoder;

    localparam int unsigned PW   = 8;
    localparam int unsigned MINP = 100;
    localparam int unsigned MAXP = 1000;
    localparam int unsigned TOLV = 4;
    localparam logic [31:0] REST = 32'hFFFF_FFFF;

    logic        sys_clk;
    logic        sys_rst;
    logic        sound_in;
    logic        tone_active;
    logic [31:0] note_target;
    logic        note_valid;
    logic        period_err;

    tone_decoder #(
        .PWM_WINDOW(PW),
        .MIN_PERIOD(MINP),
        .MAX_PERIOD(MAXP),
        .TOL       (TOLV),
        .REST_CODE (REST)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .sound_in   (sound_in),
        .tone_active(tone_active),
        .note_target(note_target),
        .note_valid (note_valid),
        .period_err (period_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int          checks   = 0;
    int          failures = 0;
    int          nv_cnt   = 0;
    int          pe_cnt   = 0;
    int          wide_cnt = 0;
    logic        nv_prev  = 1'b0;
    logic        pe_prev  = 1'b0;
    logic [31:0] last_pub = 32'hFFFF_FFFF;
    int          ph       = 0;
    int          pwm_ph   = 0;

    typedef struct {
        int          half;
        bit          pwm;
        int          periods;
        logic [31:0] exp_note;
        int          note_tol;
        bit          exp_active;
        int          exp_valid;
    } vec_t;

    vec_t vecs[7];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_near(input string name, input logic [31:0] act,
                              input logic [31:0] exp, input int tol);
        logic [31:0] d;
        checks++;
        d = (act > exp) ? act - exp : exp - act;
        if ($isunknown(act) || d > 32'(tol)) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h +/-%0d", name, act, exp, tol);
        end
    endtask

    // One clock: sample outputs on the falling edge, then drive sound_in
    task automatic tick(input logic v);
        @(negedge sys_clk);
        if (note_valid === 1'b1) begin
            nv_cnt++;
            last_pub = note_target;
        end
        if (period_err === 1'b1) pe_cnt++;
        if ((note_valid === 1'b1 && nv_prev) || (period_err === 1'b1 && pe_prev)) wide_cnt++;
        nv_prev  = (note_valid === 1'b1);
        pe_prev  = (period_err === 1'b1);
        sound_in = v;
        pwm_ph++;
    endtask

    // Square wave of the given half-period, optionally gated by a 13/16 PWM
    task automatic run_tone(input int half, input int n, input bit pwm);
        for (int i = 0; i < n; i++) begin
            tick((ph < half) && (!pwm || ((pwm_ph % 16) < 13)));
            ph = (ph + 1) % (2 * half);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        repeat (3) tick(1'b0);
        sys_rst = 1'b0;
        ph = 0;
    endtask

    initial begin
        int nv0;
        int pe0;
        int viol;

        vecs[0] = '{300, 1'b0, 8,  32'd299, 0, 1'b1, 1};
        vecs[1] = '{50,  1'b0, 8,  32'd49,  0, 1'b1, 1};
        vecs[2] = '{500, 1'b0, 5,  32'd499, 0, 1'b1, 1};
        vecs[3] = '{49,  1'b0, 10, REST,    0, 1'b0, 0};
        vecs[4] = '{501, 1'b0, 5,  REST,    0, 1'b0, 0};
        vecs[5] = '{200, 1'b1, 10, 32'd199, 2, 1'b1, 1};
        vecs[6] = '{450, 1'b1, 6,  32'd449, 2, 1'b1, 1};

        // Reset held with the line toggling: outputs stay at reset values
        sys_rst  = 1'b1;
        sound_in = 1'b0;
        tick(1'b0);
        viol = 0;
        for (int i = 0; i < 24; i++) begin
            tick(((i / 3) % 2) == 1);
            if (tone_active !== 1'b0 || note_valid !== 1'b0 || period_err !== 1'b0 ||
                note_target !== REST) viol++;
        end
        check_eq("reset_hold", 32'(viol), 32'd0);
        sys_rst = 1'b0;
        nv0 = nv_cnt;
        pe0 = pe_cnt;
        repeat (3 * MAXP + 50) tick(1'b0);
        check_eq("quiet_valid", 32'(nv_cnt - nv0), 32'd0);
        check_eq("quiet_err", 32'(pe_cnt - pe0), 32'd0);
        check_eq("quiet_note", note_target, REST);

        // Table of steady tones, each from a fresh reset
        for (int v = 0; v < 7; v++) begin
            do_reset();
            nv0 = nv_cnt;
            run_tone(vecs[v].half, vecs[v].periods * 2 * vecs[v].half, vecs[v].pwm);
            check_near($sformatf("vec%0d_note", v), note_target, vecs[v].exp_note, vecs[v].note_tol);
            check_eq($sformatf("vec%0d_active", v), 32'(tone_active), 32'(vecs[v].exp_active));
            check_eq($sformatf("vec%0d_valid", v), 32'(nv_cnt - nv0), 32'(vecs[v].exp_valid));
        end

        // Clean tone: publish exactly 4 clocks after the third rise
        do_reset();
        nv0 = nv_cnt;
        pe0 = pe_cnt;
        for (int k = 0; k <= 1204; k++) begin
            tick((k % 600) < 300);
            if (k == 1203) begin
                check_eq("lock_pre_active", 32'(tone_active), 32'd0);
                check_eq("lock_pre_note", note_target, REST);
            end
            if (k == 1204) begin
                check_eq("lock_active", 32'(tone_active), 32'd1);
                check_eq("lock_valid", 32'(note_valid), 32'd1);
                check_eq("lock_note", note_target, 32'd299);
            end
        end
        ph = 1205 % 600;
        run_tone(300, 595 + 10 * 600, 1'b0);
        check_eq("steady_valid", 32'(nv_cnt - nv0), 32'd1);
        check_eq("steady_err", 32'(pe_cnt - pe0), 32'd0);

        // Note change mid-period: one publish of the new code by the third rise
        run_tone(300, 450, 1'b0);
        ph  = 0;
        nv0 = nv_cnt;
        run_tone(150, 605, 1'b0);
        check_eq("change_note", note_target, 32'd149);
        check_eq("change_valid", 32'(nv_cnt - nv0), 32'd1);
        check_eq("change_pub", last_pub, 32'd149);
        run_tone(150, 295 + 5 * 300, 1'b0);
        check_eq("change_hold", 32'(nv_cnt - nv0), 32'd1);

        // Silence: one last rise, then the line stays low
        nv0 = nv_cnt;
        pe0 = pe_cnt;
        for (int k = 0; k <= int'(MAXP) + 4; k++) begin
            tick(k < 150);
            if (k == int'(MAXP) + 3) begin
                check_eq("sil_pre_active", 32'(tone_active), 32'd1);
            end
            if (k == int'(MAXP) + 4) begin
                check_eq("sil_active", 32'(tone_active), 32'd0);
                check_eq("sil_note", note_target, REST);
                check_eq("sil_valid", 32'(note_valid), 32'd1);
                check_eq("sil_err", 32'(period_err), 32'd1);
            end
        end
        repeat (200) tick(1'b0);
        check_eq("sil_valid_cnt", 32'(nv_cnt - nv0), 32'd1);
        check_eq("sil_err_cnt", 32'(pe_cnt - pe0), 32'd1);

        // Glitch burst while tracking: errors only, no new publish
        do_reset();
        nv0 = nv_cnt;
        run_tone(200, 1600, 1'b0);
        check_eq("glitch_lock", note_target, 32'd199);
        run_tone(200, 250, 1'b0);
        nv0 = nv_cnt;
        pe0 = pe_cnt;
        for (int g = 0; g < 1000; g++) tick((g % 40) < 20);
        ph = 0;
        run_tone(200, 1600, 1'b0);
        check_eq("glitch_err_cnt", 32'(pe_cnt - pe0), 32'd25);
        check_eq("glitch_valid", 32'(nv_cnt - nv0), 32'd0);
        check_eq("glitch_note", note_target, 32'd199);
        check_eq("glitch_active", 32'(tone_active), 32'd1);

        // Reset mid-tone: immediate return to reset values, no publish
        nv0 = nv_cnt;
        sys_rst = 1'b1;
        tick(1'b1);
        check_eq("midrst_note", note_target, REST);
        check_eq("midrst_active", 32'(tone_active), 32'd0);
        check_eq("midrst_valid", 32'(nv_cnt - nv0), 32'd0);
        sys_rst = 1'b0;
        repeat (10) tick(1'b0);

        check_eq("pulse_width", 32'(wide_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
